maze_move_ctrl: RTL and testbench

Frame-synchronous player-movement sequencer for the VGA maze game. Once every `MOVE_DIV` frames it samples the direction switches and computes the target cell. It then arbitrates for the shared maze-wall memory port, which the pixel renderer owns during active video, reads the wall bit and commits or rejects the move. It sits between the switch inputs, the VGA timing generator (`frame_tick`) and the maze RAM port arbiter. It drives the player position consumed by the renderer.

---
 rtl/maze_move_ctrl.sv | 113 +++++++++++
 tb/tb_maze_move_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl: frame-paced player movement with wall lookup over a shared maze RAM port.
// Build option MAZE_WRAP_EN: off-edge moves wrap to the opposite side instead of bumping.
module maze_move_ctrl #(
    parameter int MAZE_W   = 20,
    parameter int MAZE_H   = 15,
    parameter int X_W      = 5,
    parameter int Y_W      = 4,
    parameter int A_W      = 9,
    parameter int START_X  = 1,
    parameter int START_Y  = 1,
    parameter int GOAL_X   = 18,
    parameter int GOAL_Y   = 13,
    parameter int MOVE_DIV = 2
) (
    input  logic           MAX10_CLK1_50,
    input  logic           rst_n,
    input  logic           frame_tick,
    input  logic [3:0]     dir,
    output logic           mem_req,
    input  logic           mem_gnt,
    output logic [A_W-1:0] mem_addr,
    input  logic           mem_rvalid,
    input  logic           mem_rdata,
    output logic [X_W-1:0] pos_x,
    output logic [Y_W-1:0] pos_y,
    output logic           busy,
    output logic           bump,
    output logic           goal,
    output logic           overrun
);
    typedef enum logic [1:0] {IDLE, CHECK, REQ, WAIT} state_t;

    localparam int C_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [C_W-1:0] DIV_LAST = C_W'(MOVE_DIV - 1);
    localparam logic [C_W-1:0] C_ONE    = C_W'(1);
    localparam logic [X_W:0]   X_ONE    = (X_W+1)'(1);
    localparam logic [Y_W:0]   Y_ONE    = (Y_W+1)'(1);
    localparam logic [X_W:0]   X_LIM    = (X_W+1)'(MAZE_W);
    localparam logic [Y_W:0]   Y_LIM    = (Y_W+1)'(MAZE_H);
    localparam logic [A_W-1:0] ROW      = A_W'(MAZE_W);

    state_t         state, state_nx;
    logic [C_W-1:0] cnt;
    logic [X_W:0]   tx_raw;
    logic [Y_W:0]   ty_raw;
    logic [X_W-1:0] tx, tgt_x;
    logic [Y_W-1:0] ty, tgt_y;
    logic           one_hot, x_out, y_out, oob, reject;

    // Target is one bit wider than the position so that 0-1 lands above the limit.
    always_comb begin
        one_hot = (dir != 4'd0) && ((dir & (dir - 4'd1)) == 4'd0);
        tx_raw  = dir[0] ? {1'b0, pos_x} + X_ONE : dir[1] ? {1'b0, pos_x} - X_ONE : {1'b0, pos_x};
        ty_raw  = dir[2] ? {1'b0, pos_y} + Y_ONE : dir[3] ? {1'b0, pos_y} - Y_ONE : {1'b0, pos_y};
        x_out   = tx_raw >= X_LIM;
        y_out   = ty_raw >= Y_LIM;
`ifdef MAZE_WRAP_EN
        tx      = x_out ? (dir[1] ? X_W'(MAZE_W - 1) : '0) : tx_raw[X_W-1:0];
        ty      = y_out ? (dir[3] ? Y_W'(MAZE_H - 1) : '0) : ty_raw[Y_W-1:0];
        oob     = 1'b0;
`else
        tx      = tx_raw[X_W-1:0];
        ty      = ty_raw[Y_W-1:0];
        oob     = x_out | y_out;
`endif
        reject  = !one_hot || goal || oob;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  state_nx = (frame_tick && cnt == DIV_LAST) ? CHECK : IDLE;
            CHECK: state_nx = reject ? IDLE : REQ;
            REQ:   state_nx = mem_gnt ? WAIT : REQ;
            WAIT:  state_nx = mem_rvalid ? IDLE : WAIT;
        endcase
    end

    assign busy    = state != IDLE;
    assign mem_req = state == REQ;

    always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            pos_x    <= X_W'(START_X);
            pos_y    <= Y_W'(START_Y);
            tgt_x    <= '0;
            tgt_y    <= '0;
            mem_addr <= '0;
            bump     <= 1'b0;
            goal     <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            state   <= state_nx;
            bump    <= (state == CHECK && one_hot && !goal && oob) ||
                       (state == WAIT && mem_rvalid && mem_rdata);
            goal    <= goal || (pos_x == X_W'(GOAL_X) && pos_y == Y_W'(GOAL_Y));
            overrun <= overrun || (frame_tick && state != IDLE);
            if (state == IDLE && frame_tick)
                cnt <= (cnt == DIV_LAST) ? '0 : cnt + C_ONE;
            if (state == CHECK) begin
                tgt_x    <= tx;
                tgt_y    <= ty;
                mem_addr <= A_W'(ty) * ROW + A_W'(tx);
            end
            if (state == WAIT && mem_rvalid && !mem_rdata) begin
                pos_x <= tgt_x;
                pos_y <= tgt_y;
            end
        end
    end
endmodule

// File: tb/tb_maze_move_ctrl.sv
// tb_maze_move_ctrl: scoreboard bench; a grid-level model predicts requests, bumps, moves and goal.
module tb_maze_move_ctrl;
    localparam int MW = 20, MH = 15, SX = 1, SY = 1, GX = 18, GY = 13, DIV = 2;
    localparam int EV_REQ = 0, EV_BUMP = 1, EV_MOVE = 2, EV_GOAL = 3;
    typedef struct { int kind; int val; } ev_t;

    logic       clk = 0, rst_n = 0, frame_tick = 0;
    logic       mem_gnt, mem_rvalid, mem_rdata;
    logic [3:0] dir = 4'd0;
    logic       mem_req, busy, bump, goal, overrun;
    logic [8:0] mem_addr;
    logic [4:0] pos_x;
    logic [3:0] pos_y;

    int  tests = 0, fails = 0;
    ev_t exp_q[$];
    bit  wall[512];
    int  gnt_dly = 0, rv_dly = 0;
    int  mx = SX, my = SY, mcnt = 0, last_addr = 0;
    bit  mgoal = 0;

    maze_move_ctrl dut (
        .MAX10_CLK1_50(clk), .rst_n(rst_n), .frame_tick(frame_tick), .dir(dir),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .pos_x(pos_x), .pos_y(pos_y), .busy(busy), .bump(bump),
        .goal(goal), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not reach the summary");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    function automatic int enc(input int x, input int y);
        return y * 32 + x;
    endfunction

    task automatic push(input int k, input int v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input int val, input string name);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL %s: got unexpected event value %0d, nothing queued", name, val);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.val != val) begin
            fails++;
            $display("FAIL %s: got kind %0d value %0d, want kind %0d value %0d", name, kind, val, e.kind, e.val);
        end
    endtask

    // Monitor: every observable DUT event must match the head of the expectation queue.
    logic       req_q = 0, goal_q = 0;
    logic [8:0] pos_q = 9'(SY * 32 + SX);
    always @(negedge clk) begin
        if (mem_req && !req_q) expect_ev(EV_REQ, int'(mem_addr), "req_addr");
        if (bump) expect_ev(EV_BUMP, 0, "bump");
        if ({pos_y, pos_x} != pos_q) expect_ev(EV_MOVE, int'({pos_y, pos_x}), "move");
        if (goal && !goal_q) expect_ev(EV_GOAL, 0, "goal");
        req_q  = mem_req;
        goal_q = goal;
        pos_q  = {pos_y, pos_x};
    end

    // Memory port responder with programmable grant and read latency.
    initial begin
        int a;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        forever begin
            @(posedge clk); #1;
            if (mem_req) begin
                a = int'(mem_addr);
                repeat (gnt_dly) begin @(posedge clk); #1; end
                mem_gnt = 1;
                @(posedge clk); #1;
                mem_gnt = 0;
                repeat (rv_dly) begin @(posedge clk); #1; end
                mem_rvalid = 1;
                mem_rdata  = wall[a];
                @(posedge clk); #1;
                mem_rvalid = 0;
                mem_rdata  = 0;
            end
        end
    end

    // Reference model: grid walk with frame divider, computed directly from the movement rules.
    task automatic model_tick(input logic [3:0] d, output bit qual);
        int nx, ny;
        qual = 0;
        mcnt++;
        if (mcnt < DIV) return;
        mcnt = 0;
        qual = 1;
        if ($countones(d) != 1 || mgoal) return;
        nx = mx + (d[0] ? 1 : 0) - (d[1] ? 1 : 0);
        ny = my + (d[2] ? 1 : 0) - (d[3] ? 1 : 0);
        if (nx < 0 || nx >= MW || ny < 0 || ny >= MH) begin
`ifdef MAZE_WRAP_EN
            nx = (nx + MW) % MW;
            ny = (ny + MH) % MH;
`else
            push(EV_BUMP, 0);
            return;
`endif
        end
        last_addr = ny * MW + nx;
        push(EV_REQ, last_addr);
        if (wall[last_addr]) begin
            push(EV_BUMP, 0);
            return;
        end
        mx = nx;
        my = ny;
        push(EV_MOVE, enc(mx, my));
        if (mx == GX && my == GY) begin
            mgoal = 1;
            push(EV_GOAL, 0);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    // Returns one cycle after the tick (T+1), after checking that busy reflects the divider.
    task automatic tick(input logic [3:0] d, output bit qual);
        wait_idle();
        @(posedge clk); #1;
        dir = d;
        frame_tick = 1;
        model_tick(d, qual);
        @(posedge clk); #1;
        frame_tick = 0;
        chk("busy_after_tick", 32'(busy), 32'(qual));
    endtask

    task automatic step(input logic [3:0] d);
        bit q;
        for (int i = 0; i < DIV; i++) begin
            tick(d, q);
            if (q) return;
        end
    endtask

    initial begin
        int px, py;
        bit q;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pos_x", 32'(pos_x), SX);
        chk("rst_pos_y", 32'(pos_y), SY);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_flags", {busy, bump, goal, overrun}, 0);
        rst_n = 1;

        step(4'b0000);

        tick(4'b0001, q);
        tick(4'b0001, q);
        @(posedge clk); #1;
        chk("open_req_t2", 32'(mem_req), 1);
        chk("open_addr_t2", 32'(mem_addr), 22);
        @(posedge clk); #1;
        chk("open_req_drop_t3", 32'(mem_req), 0);
        chk("open_pos_x_t3", 32'(pos_x), 1);
        @(posedge clk); #1;
        chk("open_pos_x_t4", 32'(pos_x), 2);
        chk("open_no_bump", 32'(bump), 0);

        wall[2] = 1;
        step(4'b1000);
        wait_idle();
        chk("wall_addr", 32'(mem_addr), 2);
        chk("wall_pos_y", 32'(pos_y), 1);
        wall[2] = 0;

        step(4'b0010);
        step(4'b0010);
        step(4'b0010);
        @(posedge clk); #1;
`ifdef MAZE_WRAP_EN
        chk("edge_wrap_req", 32'(mem_req), 1);
        chk("edge_wrap_addr", 32'(mem_addr), 39);
        wait_idle();
        chk("edge_wrap_pos_x", 32'(pos_x), 19);
        step(4'b0001);
`else
        chk("edge_bump_t2", 32'(bump), 1);
        chk("edge_no_req", 32'(mem_req), 0);
`endif
        wait_idle();
        chk("edge_pos_x", 32'(pos_x), 0);

        step(4'b1001);
        step(4'b1001);
        step(4'b0011);

        gnt_dly = 5;
        step(4'b0001);
        @(posedge clk); #1;
        frame_tick = 1;
        @(posedge clk); #1;
        frame_tick = 0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_req", 32'(mem_req), 1);
            chk("stall_addr", 32'(mem_addr), 32'(last_addr));
            @(posedge clk); #1;
        end
        chk("overrun", 32'(overrun), 1);
        gnt_dly = 0;
        wait_idle();

        rv_dly = 5;
        px = mx;
        py = my;
        step(4'b0100);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wait_busy", 32'(busy), 1);
        chk("wait_req", 32'(mem_req), 0);
        exp_q.delete();
        if (px != SX || py != SY) push(EV_MOVE, enc(SX, SY));
        rst_n = 0;
        #1;
        chk("async_rst_busy", 32'(busy), 0);
        chk("async_rst_addr", 32'(mem_addr), 0);
        mx = SX; my = SY; mcnt = 0; mgoal = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        repeat (8) @(posedge clk);
        #1;
        chk("late_rvalid_pos", {pos_y, pos_x}, enc(SX, SY));
        chk("rst_overrun", 32'(overrun), 0);
        rv_dly = 0;

        for (int i = 0; i < 512; i++) wall[i] = ($urandom_range(0, 3) == 0);
        for (int i = 0; i < 80; i++) begin
            logic [3:0] d;
            d = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            gnt_dly = $urandom_range(0, 3);
            rv_dly  = $urandom_range(0, 3);
            tick(d, q);
            @(posedge clk); #1;
            dir = 4'($urandom_range(0, 15));
        end

        wait_idle();
        for (int i = 0; i < 512; i++) wall[i] = 0;
        gnt_dly = 0;
        rv_dly  = 0;
        for (int i = 0; i < 100 && !mgoal; i++)
            step(mx < GX ? 4'b0001 : mx > GX ? 4'b0010 : my < GY ? 4'b0100 : 4'b1000);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;
        chk("goal_flag", 32'(goal), 1);
        chk("goal_pos", {pos_y, pos_x}, enc(GX, GY));
        step(4'b0010);
        step(4'b1000);
        wait_idle();
        repeat (5) @(posedge clk);
        #1;
        chk("goal_hold_pos", {pos_y, pos_x}, enc(GX, GY));
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
